// File: rtl/i2s_codec_slave.sv
// rtl/i2s_codec_slave.sv - codec-side I2S endpoint: DACDAT deserialiser and ADCDAT serialiser
module i2s_codec_slave #(
   parameter int DATA_WIDTH = 16,
   parameter int CNT_W      = 5
) (
   input  logic                  iCLK_18_4,
   input  logic                  iRST_N,
   input  logic                  iAUD_BCLK,
   input  logic                  iAUD_LRCK,
   input  logic                  iAUD_DACDAT,
   output logic                  oAUD_ADCDAT,
   input  logic [DATA_WIDTH-1:0] iTX_L,
   input  logic [DATA_WIDTH-1:0] iTX_R,
   output logic [DATA_WIDTH-1:0] oRX_L,
   output logic [DATA_WIDTH-1:0] oRX_R,
   output logic                  oRX_VALID_L,
   output logic                  oRX_VALID_R,
   output logic                  oSHORT_ERR
);

   localparam logic [CNT_W-1:0] FULL = CNT_W'(DATA_WIDTH);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   // [0] metastable stage, [1] synchronised level, [2] history
   logic [2:0] bclk_q;
   logic [2:0] lrck_q;
   logic [1:0] dac_q;
   // Edge decode stays masked until the pipelines hold real pin levels,
   // so leaving reset never produces a spurious edge.
   logic [1:0] warm_q;

   logic edges_en, bclk_rise, bclk_fall, lr_edge, lr_lvl, din;

   logic [CNT_W-1:0]      rx_cnt_q,   rx_cnt_d;
   logic [DATA_WIDTH-2:0] rx_shift_q, rx_shift_d;
   logic [DATA_WIDTH-1:0] rx_l_q,     rx_l_d;
   logic [DATA_WIDTH-1:0] rx_r_q,     rx_r_d;
   logic                  valid_l_q,  valid_l_d;
   logic                  valid_r_q,  valid_r_d;
   logic                  short_err_q, short_err_d;
   logic                  armed_q,    armed_d;
   logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
   logic [DATA_WIDTH-1:0] rx_word;

   // Pin synchronisers, history flops and post-reset warm-up counter
   always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
      if (!iRST_N) begin
         bclk_q <= '0;
         lrck_q <= '0;
         dac_q  <= '0;
         warm_q <= '0;
      end else begin
         bclk_q <= {bclk_q[1:0], iAUD_BCLK};
         lrck_q <= {lrck_q[1:0], iAUD_LRCK};
         dac_q  <= {dac_q[0], iAUD_DACDAT};
         if (warm_q != 2'd3) begin
            warm_q <= warm_q + 2'd1;
         end
      end
   end

   assign edges_en  = (warm_q == 2'd3);
   assign bclk_rise = edges_en & bclk_q[1] & ~bclk_q[2];
   assign bclk_fall = edges_en & ~bclk_q[1] & bclk_q[2];
   assign lr_edge   = edges_en & (lrck_q[1] ^ lrck_q[2]);
   assign lr_lvl    = lrck_q[1];
   assign din       = dac_q[1];
   assign rx_word   = {rx_shift_q, din};

   // Receive next-state: slot restart on LRCK edge, MSB-first shift, saturating count.
   // Nothing is captured until the first LRCK edge after reset (armed_q).
   always_comb begin
      rx_cnt_d    = rx_cnt_q;
      rx_shift_d  = rx_shift_q;
      rx_l_d      = rx_l_q;
      rx_r_d      = rx_r_q;
      valid_l_d   = 1'b0;
      valid_r_d   = 1'b0;
      short_err_d = 1'b0;
      armed_d     = armed_q;
      if (lr_edge) begin
         short_err_d = (rx_cnt_q != '0) && (rx_cnt_q < FULL);
         armed_d     = 1'b1;
         rx_cnt_d    = '0;
         rx_shift_d  = '0;
         if (bclk_rise) begin
            rx_cnt_d   = ONE;
            rx_shift_d = {{(DATA_WIDTH-2){1'b0}}, din};
         end
      end else if (bclk_rise && armed_q && (rx_cnt_q < FULL)) begin
         rx_cnt_d   = rx_cnt_q + ONE;
         rx_shift_d = rx_word[DATA_WIDTH-2:0];
         if (rx_cnt_q == FULL - ONE) begin
            if (lr_lvl) begin
               rx_l_d    = rx_word;
               valid_l_d = 1'b1;
            end else begin
               rx_r_d    = rx_word;
               valid_r_d = 1'b1;
            end
         end
      end
   end

   // Transmit next-state: load on LRCK edge (wins over a coincident fall), shift on fall
   always_comb begin
      tx_shift_d = tx_shift_q;
      if (lr_edge) begin
         tx_shift_d = lr_lvl ? iTX_L : iTX_R;
      end else if (bclk_fall) begin
         tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
      end
   end

   // Datapath state registers
   always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
      if (!iRST_N) begin
         rx_cnt_q    <= '0;
         rx_shift_q  <= '0;
         rx_l_q      <= '0;
         rx_r_q      <= '0;
         valid_l_q   <= 1'b0;
         valid_r_q   <= 1'b0;
         short_err_q <= 1'b0;
         armed_q     <= 1'b0;
         tx_shift_q  <= '0;
      end else begin
         rx_cnt_q    <= rx_cnt_d;
         rx_shift_q  <= rx_shift_d;
         rx_l_q      <= rx_l_d;
         rx_r_q      <= rx_r_d;
         valid_l_q   <= valid_l_d;
         valid_r_q   <= valid_r_d;
         short_err_q <= short_err_d;
         armed_q     <= armed_d;
         tx_shift_q  <= tx_shift_d;
      end
   end

   assign oAUD_ADCDAT = tx_shift_q[DATA_WIDTH-1];
   assign oRX_L       = rx_l_q;
   assign oRX_R       = rx_r_q;
   assign oRX_VALID_L = valid_l_q;
   assign oRX_VALID_R = valid_r_q;
   assign oSHORT_ERR  = short_err_q;

endmodule

// File: tb/tb_i2s_codec_slave.sv
// tb/tb_i2s_codec_slave.sv - scoreboard bench for i2s_codec_slave with I2S master model
module tb_i2s_codec_slave;

   localparam int HP = 4;   // system clocks per BCLK half period

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        bclk = 1'b0;
   logic        lrck = 1'b0;
   logic        dac = 1'b0;
   logic        adc;
   logic [15:0] tx_l = 16'h0;
   logic [15:0] tx_r = 16'h0;
   logic [15:0] rx_l, rx_r;
   logic        vl, vr, serr;

   always #5 clk = ~clk;

   i2s_codec_slave #(.DATA_WIDTH(16), .CNT_W(5)) dut (
      .iCLK_18_4   (clk),
      .iRST_N      (rst_n),
      .iAUD_BCLK   (bclk),
      .iAUD_LRCK   (lrck),
      .iAUD_DACDAT (dac),
      .oAUD_ADCDAT (adc),
      .iTX_L       (tx_l),
      .iTX_R       (tx_r),
      .oRX_L       (rx_l),
      .oRX_R       (rx_r),
      .oRX_VALID_L (vl),
      .oRX_VALID_R (vr),
      .oSHORT_ERR  (serr)
   );

   // kind: 0 = left word, 1 = right word, 2 = short-slot error
   typedef struct {
      int          kind;
      logic [15:0] data;
   } ev_t;

   typedef struct {
      logic [31:0] got;
      logic [31:0] want;
   } tx_t;

   ev_t sb_q[$];
   tx_t txq[$];

   int errors = 0;
   int checks = 0;
   logic [15:0] last_l = 16'h0;
   logic [15:0] last_r = 16'h0;
   bit final_req = 1'b0;
   bit final_done = 1'b0;

   // Master-side memory: ADC words captured last frame and the iTX words that produced them
   logic [15:0] cap_l = 16'h0, cap_r = 16'h0, ptx_l = 16'h0, ptx_r = 16'h0;

   task automatic expect_ev(input int kind, input logic [15:0] data);
      ev_t e;
      checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $display("FAIL event_unexpected: got kind=%0d data=%h, required no event", kind, data);
      end else begin
         e = sb_q.pop_front();
         if (e.kind != kind || e.data != data) begin
            errors++;
            $display("FAIL event: got kind=%0d data=%h, required kind=%0d data=%h",
                     kind, data, e.kind, e.data);
         end
      end
   endtask

   // Monitor: samples mid-low-phase, pops the scoreboard on every output event
   always @(negedge clk) begin
      tx_t t;
      #2;
      if (!rst_n) begin
         checks++;
         if ({adc, rx_l, rx_r, vl, vr, serr} != 35'h0) begin
            errors++;
            $display("FAIL reset_outputs: got adc=%b rx_l=%h rx_r=%h vl=%b vr=%b err=%b, required all 0",
                     adc, rx_l, rx_r, vl, vr, serr);
         end
         last_l = 16'h0;
         last_r = 16'h0;
      end else begin
         if (vl) begin
            expect_ev(0, rx_l);
            last_l = rx_l;
         end else begin
            checks++;
            if (rx_l != last_l) begin
               errors++;
               $display("FAIL rx_l_stable: got %h, required %h", rx_l, last_l);
            end
         end
         if (vr) begin
            expect_ev(1, rx_r);
            last_r = rx_r;
         end else begin
            checks++;
            if (rx_r != last_r) begin
               errors++;
               $display("FAIL rx_r_stable: got %h, required %h", rx_r, last_r);
            end
         end
         if (serr) expect_ev(2, 16'h0);
      end
      while (txq.size() > 0) begin
         t = txq.pop_front();
         checks++;
         if (t.got !== t.want) begin
            errors++;
            $display("FAIL adc_slot: got %h, required %h", t.got, t.want);
         end
      end
      if (final_req && !final_done) begin
         checks++;
         if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL events_missing: got %0d outstanding, required 0", sb_q.size());
         end
         final_done = 1'b1;
      end
   end

   // One slot of a left-justified master: LRCK and data change on BCLK fall,
   // ADCDAT is captured on BCLK rise. Expected events go to the scoreboard up front.
   task automatic run_slot(input logic lr, input logic [15:0] word, input int nbits,
                           input int exp_kind, input logic [15:0] exp_rx,
                           input int chg_bit, input logic [15:0] chg_val, input int rst_bit);
      logic [31:0] adc_bits;
      logic [15:0] txw;
      ev_t e;
      adc_bits = 32'h0;
      txw = lr ? tx_l : tx_r;
      if (exp_kind >= 0) begin
         e.kind = exp_kind;
         e.data = exp_rx;
         sb_q.push_back(e);
      end
      if (nbits > 0 && nbits < 16) begin
         e.kind = 2;
         e.data = 16'h0;
         sb_q.push_back(e);
      end
      for (int i = 0; i < nbits; i++) begin
         bclk = 1'b0;
         if (i == 0) lrck = lr;
         dac = (i < 16) ? word[15-i] : 1'($urandom);
         if (i == chg_bit) tx_l = chg_val;
         if (i == rst_bit) begin
            rst_n = 1'b0;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            repeat (HP-2) @(negedge clk);
         end else begin
            repeat (HP) @(negedge clk);
         end
         bclk = 1'b1;
         adc_bits[31-i] = adc;
         repeat (HP) @(negedge clk);
      end
      if (nbits == 32 && rst_bit < 0) begin
         tx_t t;
         t.got  = adc_bits;
         t.want = {txw, 16'h0};
         txq.push_back(t);
         if (lr) begin
            cap_l = adc_bits[31:16];
            ptx_l = txw;
         end else begin
            cap_r = adc_bits[31:16];
            ptx_r = txw;
         end
      end
   endtask

   initial begin
      logic [15:0] w;
      logic [15:0] exp_l, exp_r;
      #1 rst_n = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);

      // Fixed pattern both directions
      tx_l = 16'h1234;
      tx_r = 16'hFEDC;
      for (int f = 0; f < 3; f++) begin
         run_slot(1'b1, 16'h6000, 32, 0, 16'h6000, -1, 16'h0, -1);
         run_slot(1'b0, 16'hA000, 32, 1, 16'hA000, -1, 16'h0, -1);
      end

      // Short left slot: error only, outputs hold, then full slots recover
      w = 16'($urandom);
      run_slot(1'b1, w, 9, -1, 16'h0, -1, 16'h0, -1);
      run_slot(1'b0, 16'h5A5A, 32, 1, 16'h5A5A, -1, 16'h0, -1);
      run_slot(1'b1, 16'h3C3C, 32, 0, 16'h3C3C, -1, 16'h0, -1);

      // iTX_L changed mid-slot only affects the next left slot
      tx_l = 16'h1234;
      run_slot(1'b0, 16'h0F0F, 32, 1, 16'h0F0F, -1, 16'h0, -1);
      run_slot(1'b1, 16'h8001, 32, 0, 16'h8001, 5, 16'h0000, -1);
      run_slot(1'b0, 16'h7FFE, 32, 1, 16'h7FFE, -1, 16'h0, -1);
      run_slot(1'b1, 16'hC3C3, 32, 0, 16'hC3C3, -1, 16'h0, -1);
      run_slot(1'b0, 16'h0001, 32, 1, 16'h0001, -1, 16'h0, -1);

      // Loopback through the master: rx this frame = iTX of the previous frame
      for (int f = 0; f < 60; f++) begin
         exp_l = ptx_l;
         exp_r = ptx_r;
         tx_l = 16'($urandom);
         tx_r = 16'($urandom);
         run_slot(1'b1, cap_l, 32, 0, exp_l, -1, 16'h0, -1);
         run_slot(1'b0, cap_r, 32, 1, exp_r, -1, 16'h0, -1);
      end

      // Reset at bit 7 of a left slot: no report for it, next right slot decodes
      tx_l = 16'hBEEF;
      tx_r = 16'h4321;
      w = 16'($urandom);
      run_slot(1'b1, w, 32, -1, 16'h0, -1, 16'h0, 7);
      run_slot(1'b0, 16'h1357, 32, 1, 16'h1357, -1, 16'h0, -1);
      run_slot(1'b1, 16'h2468, 32, 0, 16'h2468, -1, 16'h0, -1);

      repeat (20) @(negedge clk);
      final_req = 1'b1;
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
